// File: rtl/iob_gray_counter_ud_pkg.sv
// Shared defaults for the up/down Gray counter and the pointer logic that reuses it.
package iob_gray_counter_ud_pkg;

    localparam int GCU_W_DEF       = 4;
    localparam int GCU_SAT_DEF     = 0;
    localparam int GCU_RST_VAL_DEF = 0;

endpackage

// File: rtl/iob_bin2gray.sv
// Combinational binary-to-Gray converter; also used by FIFO pointer logic.
module iob_bin2gray #(
    parameter int W = 4
) (
    input  logic [W-1:0] bin_i,
    output logic [W-1:0] gray_o
);

    generate
        if (W == 1) begin : g_w1
            assign gray_o = bin_i;
        end else begin : g_wn
            assign gray_o = bin_i ^ (bin_i >> 1);
        end
    endgenerate

endmodule

// File: rtl/iob_gray_counter_ud.sv
// Up/down counter keeping a binary count and its registered Gray code in lock-step,
// with synchronous load, wrap/saturate mode and registered boundary flags.
module iob_gray_counter_ud
    import iob_gray_counter_ud_pkg::*;
#(
    parameter int W       = GCU_W_DEF,
    parameter int SAT     = GCU_SAT_DEF,
    parameter int RST_VAL = GCU_RST_VAL_DEF
) (
    input  logic         clk_i,
    input  logic         cke_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         up_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    output logic [W-1:0] bin_o,
    output logic [W-1:0] gray_o,
    output logic         zero_o,
    output logic         max_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] MAX_BIN = '1;
    localparam logic [W-1:0] RST_BIN = W'(RST_VAL);
    localparam logic [W-1:0] ONE     = W'(1);

    logic [W-1:0] bin_q;
    logic [W-1:0] gray_q;
    logic         zero_q;
    logic         max_q;
    logic         wrap_q;

    logic [W-1:0] bin_nxt;
    logic [W-1:0] gray_nxt;
    logic         wrap_nxt;

    // Reset is folded into the next-state mux so the single converter also
    // produces the reset Gray value.
    always_comb begin
        bin_nxt  = bin_q;
        wrap_nxt = 1'b0;
        if (rst_i) begin
            bin_nxt = RST_BIN;
        end else if (ld_i) begin
            bin_nxt = ld_val_i;
        end else if (en_i) begin
            if (up_i) begin
                if (bin_q == MAX_BIN) begin
                    wrap_nxt = 1'b1;
                    bin_nxt  = (SAT != 0) ? bin_q : '0;
                end else begin
                    bin_nxt = bin_q + ONE;
                end
            end else begin
                if (bin_q == '0) begin
                    wrap_nxt = 1'b1;
                    bin_nxt  = (SAT != 0) ? bin_q : MAX_BIN;
                end else begin
                    bin_nxt = bin_q - ONE;
                end
            end
        end
    end

    iob_bin2gray #(
        .W(W)
    ) u_bin2gray (
        .bin_i  (bin_nxt),
        .gray_o (gray_nxt)
    );

    // Single register group; reset overrides the clock enable.
    always_ff @(posedge clk_i) begin
        if (rst_i || cke_i) begin
            bin_q  <= bin_nxt;
            gray_q <= gray_nxt;
            zero_q <= (bin_nxt == '0);
            max_q  <= (bin_nxt == MAX_BIN);
            wrap_q <= wrap_nxt;
        end
    end

    assign bin_o  = bin_q;
    assign gray_o = gray_q;
    assign zero_o = zero_q;
    assign max_o  = max_q;
    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_iob_gray_counter_ud.sv
// Bench for iob_gray_counter_ud: three parameterisations driven by shared stimulus,
// compared every cycle against an arithmetic model, plus literal spot checks.
module tb_iob_gray_counter_ud;

    localparam int N = 3;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       cke = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       ld = 1'b0;
    logic [3:0] ld_val = 4'd0;

    logic [3:0] a_bin, a_gray, b_bin, b_gray;
    logic       c_bin, c_gray;
    logic       a_zero, a_max, a_wrap, b_zero, b_max, b_wrap, c_zero, c_max, c_wrap;

    iob_gray_counter_ud #(.W(4), .SAT(0), .RST_VAL(5)) dut_a (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .en_i(en), .up_i(up), .ld_i(ld),
        .ld_val_i(ld_val), .bin_o(a_bin), .gray_o(a_gray), .zero_o(a_zero),
        .max_o(a_max), .wrap_o(a_wrap)
    );

    iob_gray_counter_ud #(.W(4), .SAT(1), .RST_VAL(0)) dut_b (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .en_i(en), .up_i(up), .ld_i(ld),
        .ld_val_i(ld_val), .bin_o(b_bin), .gray_o(b_gray), .zero_o(b_zero),
        .max_o(b_max), .wrap_o(b_wrap)
    );

    iob_gray_counter_ud #(.W(1), .SAT(0), .RST_VAL(0)) dut_c (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .en_i(en), .up_i(up), .ld_i(ld),
        .ld_val_i(ld_val[0:0]), .bin_o(c_bin), .gray_o(c_gray), .zero_o(c_zero),
        .max_o(c_max), .wrap_o(c_wrap)
    );

    // model
    int    pw[N]   = '{4, 4, 1};
    int    psat[N] = '{0, 1, 0};
    int    prv[N]  = '{5, 0, 0};
    string nm[N]   = '{"a", "b", "c"};
    int    m_bin[N];
    int    m_wrap[N];

    typedef struct packed {
        logic [3:0] bin;
        logic [3:0] gray;
        logic       zero;
        logic       mx;
        logic       wrap;
        logic       step1;
        logic [3:0] pgray;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    // driver: apply one cycle of inputs, advance the model, queue expectations
    task automatic step(input logic r, input logic c, input logic l, input logic e,
                        input logic u, input logic [3:0] v);
        @(negedge clk);
        rst = r; cke = c; ld = l; en = e; up = u; ld_val = v;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            int   mx = (1 << pw[i]) - 1;
            int   pg = gray_of(m_bin[i]);
            logic s1 = 1'b0;
            exp_t x;
            if (r) begin
                m_bin[i] = prv[i]; m_wrap[i] = 0;
            end else if (!c) begin
                // everything holds
            end else if (l) begin
                m_bin[i] = int'(v) & mx; m_wrap[i] = 0;
            end else if (e) begin
                if (u) begin
                    if (m_bin[i] == mx) begin
                        m_wrap[i] = 1;
                        if (psat[i] == 0) begin m_bin[i] = 0; s1 = 1'b1; end
                    end else begin
                        m_bin[i] = m_bin[i] + 1; m_wrap[i] = 0; s1 = 1'b1;
                    end
                end else begin
                    if (m_bin[i] == 0) begin
                        m_wrap[i] = 1;
                        if (psat[i] == 0) begin m_bin[i] = mx; s1 = 1'b1; end
                    end else begin
                        m_bin[i] = m_bin[i] - 1; m_wrap[i] = 0; s1 = 1'b1;
                    end
                end
            end else begin
                m_wrap[i] = 0;
            end
            x.bin   = 4'(m_bin[i]);
            x.gray  = 4'(gray_of(m_bin[i]));
            x.zero  = (m_bin[i] == 0);
            x.mx    = (m_bin[i] == mx);
            x.wrap  = (m_wrap[i] != 0);
            x.step1 = s1;
            x.pgray = 4'(pg);
            exp_q.push_back(x);
        end
    endtask

    // scoreboard: compare every instance on every falling edge
    always @(negedge clk) begin
        while (exp_q.size() >= N) begin
            for (int i = 0; i < N; i++) begin
                exp_t e;
                int ab, ag, az, am, aw;
                e = exp_q.pop_front();
                case (i)
                    0:       begin ab = int'(a_bin); ag = int'(a_gray); az = int'(a_zero); am = int'(a_max); aw = int'(a_wrap); end
                    1:       begin ab = int'(b_bin); ag = int'(b_gray); az = int'(b_zero); am = int'(b_max); aw = int'(b_wrap); end
                    default: begin ab = int'(c_bin); ag = int'(c_gray); az = int'(c_zero); am = int'(c_max); aw = int'(c_wrap); end
                endcase
                check({nm[i], "_bin"},  ab, int'(e.bin));
                check({nm[i], "_gray"}, ag, int'(e.gray));
                check({nm[i], "_zero"}, az, int'(e.zero));
                check({nm[i], "_max"},  am, int'(e.mx));
                check({nm[i], "_wrap"}, aw, int'(e.wrap));
                if (e.step1)
                    check({nm[i], "_gray_onebit"}, $countones(4'(ag) ^ e.pgray), 1);
            end
        end
    end

    int gtab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
    int a_wraps;

    initial begin
        // reset values
        step(1, 1, 0, 0, 1, 4'd0);
        #1;
        check("rst_a_bin", int'(a_bin), 5);
        check("rst_a_gray", int'(a_gray), 7);
        check("rst_a_zero", int'(a_zero), 0);
        check("rst_a_max", int'(a_max), 0);
        check("rst_a_wrap", int'(a_wrap), 0);

        // reset dominates cke=0 and load
        step(0, 1, 0, 1, 1, 4'd0);
        step(1, 0, 1, 1, 1, 4'd3);
        #1;
        check("rst_dom_a_bin", int'(a_bin), 5);
        check("rst_dom_a_gray", int'(a_gray), 7);

        // count up 20 from 0
        step(0, 1, 1, 0, 1, 4'd0);
        a_wraps = 0;
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 0, 1, 1, 4'd0);
            #1;
            if (a_wrap) a_wraps++;
            check("up_a_gray", int'(a_gray), gtab[(k + 1) % 16]);
            check("up_a_wrap", int'(a_wrap), (k == 15) ? 1 : 0);
            check("up_b_bin", int'(b_bin), (k + 1 > 15) ? 15 : k + 1);
            check("up_b_wrap", int'(b_wrap), (k >= 15) ? 1 : 0);
            check("up_c_bin", int'(c_bin), (k + 1) % 2);
            check("up_c_gray", int'(c_gray), (k + 1) % 2);
            check("up_c_wrap", int'(c_wrap), (k % 2 == 1) ? 1 : 0);
        end
        check("up_a_wrap_count", a_wraps, 1);

        // count down from 0
        step(0, 1, 1, 0, 1, 4'd0);
        step(0, 1, 0, 1, 0, 4'd0);
        #1;
        check("dn_a_bin", int'(a_bin), 15);
        check("dn_a_gray", int'(a_gray), 8);
        check("dn_a_max", int'(a_max), 1);
        check("dn_a_wrap", int'(a_wrap), 1);
        check("dn_b_bin", int'(b_bin), 0);
        check("dn_b_wrap", int'(b_wrap), 1);
        check("dn_c_bin", int'(c_bin), 1);
        step(0, 1, 0, 0, 0, 4'd0);
        #1;
        check("hold_a_wrap", int'(a_wrap), 0);
        check("hold_a_bin", int'(a_bin), 15);

        // load beats enable
        step(0, 1, 1, 1, 1, 4'd9);
        #1;
        check("ld_a_bin", int'(a_bin), 9);
        check("ld_a_gray", int'(a_gray), 13);
        check("ld_a_wrap", int'(a_wrap), 0);

        // clock enable low freezes load and count
        step(0, 0, 1, 1, 1, 4'd2);
        step(0, 0, 0, 1, 1, 4'd0);
        #1;
        check("cke_a_bin", int'(a_bin), 9);
        check("cke_a_gray", int'(a_gray), 13);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            step(($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
